// File: rtl/keypad_scanner_if.sv
// Keypad-side signal bundle for keypad_scanner: column sense in, row drive,
// debounced key word and new-key strobe out.
interface keypad_scanner_if;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [15:0] keypad_word;
  logic        key_strobe;

  modport master (output col_n, input row_n, input keypad_word, input key_strobe);
  modport slave  (input col_n, output row_n, output keypad_word, output key_strobe);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks the rows, debounces the first active key,
// and presents {held, idx, row one-hot, col one-hot} for the processor's keypad port.
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  keypad_scanner_if.slave  io_kp
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;

  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [1:0]    r_state;
  logic [PW-1:0] r_pre;
  logic [1:0]    r_row_idx;
  logic [3:0]    r_col_sel;
  logic [DW-1:0] r_deb_cnt;
  logic [DW-1:0] r_rel_cnt;
  logic [15:0]   r_word;
  logic          r_strobe;

  logic [3:0] w_col;
  logic [3:0] w_low_col;
  logic [3:0] w_row_oh;
  logic [1:0] w_col_pos;
  logic [3:0] w_idx;
  logic       w_tick;
  logic       w_key_active;

  assign w_col        = ~r_sync2;
  // Isolate the lowest active column so simultaneous presses resolve deterministically.
  assign w_low_col    = w_col & (~w_col + 4'd1);
  assign w_row_oh     = 4'b0001 << r_row_idx;
  assign w_tick       = (r_state == ST_SCAN) && (r_pre == PRE_MAX);
  assign w_key_active = |(w_col & r_col_sel);
  assign w_idx        = {r_row_idx, w_col_pos};

  always_comb begin
    w_col_pos = 2'd0;
    case (r_col_sel)
      4'b0010: w_col_pos = 2'd1;
      4'b0100: w_col_pos = 2'd2;
      4'b1000: w_col_pos = 2'd3;
      default: w_col_pos = 2'd0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 4'b1111;
      r_sync2 <= 4'b1111;
    end else begin
      r_sync1 <= io_kp.col_n;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_SCAN;
      r_pre     <= '0;
      r_row_idx <= 2'd0;
      r_col_sel <= 4'b0000;
      r_deb_cnt <= '0;
      r_rel_cnt <= '0;
      r_word    <= 16'h0000;
      r_strobe  <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      case (r_state)
        ST_SCAN: begin
          if (w_tick) begin
            r_pre <= '0;
            if (|w_col) begin
              r_col_sel <= w_low_col;
              r_deb_cnt <= '0;
              r_state   <= ST_DEBOUNCE;
            end else begin
              r_row_idx <= r_row_idx + 2'd1;
            end
          end else begin
            r_pre <= r_pre + PW'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (w_key_active) begin
            if (r_deb_cnt == DEB_MAX) begin
              r_word    <= {1'b1, 3'b000, w_idx, w_row_oh, r_col_sel};
              r_strobe  <= 1'b1;
              r_rel_cnt <= '0;
              r_state   <= ST_HELD;
            end else begin
              r_deb_cnt <= r_deb_cnt + DW'(1);
            end
          end else begin
            r_row_idx <= r_row_idx + 2'd1;
            r_state   <= ST_SCAN;
          end
        end
        ST_HELD: begin
          // Any re-assertion of the tracked key restarts the release window.
          if (w_key_active) begin
            r_rel_cnt <= '0;
          end else if (r_rel_cnt == DEB_MAX) begin
            r_word[15] <= 1'b0;
            r_rel_cnt  <= '0;
            r_row_idx  <= r_row_idx + 2'd1;
            r_state    <= ST_SCAN;
          end else begin
            r_rel_cnt <= r_rel_cnt + DW'(1);
          end
        end
        default: r_state <= ST_SCAN;
      endcase
    end
  end

  assign io_kp.row_n       = ~w_row_oh;
  assign io_kp.keypad_word = r_word;
  assign io_kp.key_strobe  = r_strobe;

endmodule
